// File: rtl/ac97_pcm_pkg.sv
// ac97_pcm_pkg: shared types and constants for the AC97 PCM output buffer.
// Holds the default slot width, the FIFO state encoding and saturation limits.
package ac97_pcm_pkg;

  // Default AC97 slot width in bits.
  localparam int OUT_W_DEF = 20;

  // PRIME waits for the FIFO to fill. RUN streams pairs to the frame controller.
  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Largest positive value representable in a w-bit signed sample.
  function automatic logic signed [31:0] sat_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  // Most negative value representable in a w-bit signed sample.
  function automatic logic signed [31:0] sat_min(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

  // Saturation limits for the default slot width.
  localparam logic signed [31:0] SAT_MAX_DEF = sat_max(OUT_W_DEF);
  localparam logic signed [31:0] SAT_MIN_DEF = sat_min(OUT_W_DEF);

endpackage

// File: rtl/pcm_sat.sv
// pcm_sat: arithmetic right shift of a 32-bit signed PCM sample followed by
// saturation to an OUT_W-bit signed slot value. Purely combinational.
module pcm_sat
  import ac97_pcm_pkg::*;
#(
  parameter int SHIFT = 8,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic signed [31:0]      pcm,
  output logic        [OUT_W-1:0] sample
);

  localparam logic signed [31:0] LIM_MAX = sat_max(OUT_W);
  localparam logic signed [31:0] LIM_MIN = sat_min(OUT_W);

  logic signed [31:0] shifted;

  assign shifted = pcm >>> SHIFT;

  // Clamp the shifted value into the slot range, otherwise keep its low bits.
  always_comb begin
    sample = shifted[OUT_W-1:0];
    if (shifted > LIM_MAX) begin
      sample = LIM_MAX[OUT_W-1:0];
    end else if (shifted < LIM_MIN) begin
      sample = LIM_MIN[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/ac97_pcm_buffer.sv
// ac97_pcm_buffer: scales synth PCM pairs to AC97 slot width, buffers them in a
// stereo FIFO and hands one pair per frame request, with prime-before-play and
// sticky overflow/underflow flags.
// Optional macro AC97_PCM_HOLD_EN: PRIME and underrun replies repeat the last
// popped pair instead of returning zero data.
module ac97_pcm_buffer
  import ac97_pcm_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PRIME_LVL = 8,
  parameter int SHIFT     = 8,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic                       Sys_clk,
  input  logic                       Sys_rst_n,
  input  logic                       Syn_ce,
  input  logic                       In_valid,
  input  logic signed [31:0]         PCM_L,
  input  logic signed [31:0]         PCM_R,
  input  logic                       Frame_req,
  input  logic                       Clr_flags,
  output logic                       Out_valid,
  output logic [OUT_W-1:0]           Out_L,
  output logic [OUT_W-1:0]           Out_R,
  output logic [$clog2(DEPTH):0]     Level,
  output logic                       Running,
  output logic                       Ovf,
  output logic                       Udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LV  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LV = LW'(PRIME_LVL);

  state_t               state;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [2*OUT_W-1:0]   mem [DEPTH];
  logic [OUT_W-1:0]     sat_l;
  logic [OUT_W-1:0]     sat_r;
  logic                 full;
  logic                 empty;
  logic                 wr_req;
  logic                 pop;
  logic                 do_write;
  logic                 ovf_set;
  logic                 udf_set;

  pcm_sat #(.SHIFT(SHIFT), .OUT_W(OUT_W)) u_sat_l (.pcm(PCM_L), .sample(sat_l));
  pcm_sat #(.SHIFT(SHIFT), .OUT_W(OUT_W)) u_sat_r (.pcm(PCM_R), .sample(sat_r));

  assign full     = (Level == FULL_LV);
  assign empty    = (Level == '0);
  assign wr_req   = In_valid & Syn_ce;
  assign pop      = Frame_req & (state == ST_RUN) & ~empty;
  assign do_write = wr_req & (~full | pop);
  assign ovf_set  = wr_req & full & ~pop;
  assign udf_set  = Frame_req & (state == ST_RUN) & empty;
  assign Running  = (state == ST_RUN);

  // Pair storage; contents need no reset because the pointers define validity.
  always_ff @(posedge Sys_clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {sat_l, sat_r};
    end
  end

  // Pointers and occupancy; a simultaneous write and pop leaves Level unchanged.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Level  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, pop})
        2'b10:   Level <= Level + LW'(1);
        2'b01:   Level <= Level - LW'(1);
        default: Level <= Level;
      endcase
    end
  end

  // Prime/run control: release once primed, fall back to PRIME on underrun.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state <= ST_PRIME;
    end else begin
      case (state)
        ST_PRIME: if (Level >= PRIME_LV) state <= ST_RUN;
        ST_RUN:   if (udf_set) state <= ST_PRIME;
        default:  state <= ST_PRIME;
      endcase
    end
  end

  // Every frame request gets a reply one cycle later; data is the popped pair
  // or, when nothing is popped, zero or the held last pair.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      Out_valid <= 1'b0;
      Out_L     <= '0;
      Out_R     <= '0;
    end else begin
      Out_valid <= Frame_req;
      if (pop) begin
        {Out_L, Out_R} <= mem[rd_ptr];
      end else if (Frame_req) begin
`ifdef AC97_PCM_HOLD_EN
        Out_L <= Out_L;
        Out_R <= Out_R;
`else
        Out_L <= '0;
        Out_R <= '0;
`endif
      end
    end
  end

  // Sticky error flags; a set condition in the same cycle beats Clr_flags.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      Ovf <= 1'b0;
      Udf <= 1'b0;
    end else begin
      if (ovf_set)        Ovf <= 1'b1;
      else if (Clr_flags) Ovf <= 1'b0;
      if (udf_set)        Udf <= 1'b1;
      else if (Clr_flags) Udf <= 1'b0;
    end
  end

endmodule
